// File: rtl/inst_encoder_if.sv
// Symbolic-instruction request stream and encoded-word response stream.
// The master drives requests and accepts words; the encoder is the slave.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_last
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_last
  );
endinterface

// File: rtl/inst_encoder.sv
// Streaming MIPS instruction encoder with LI -> LUI/ORI expansion.
// Optional IMM_RANGE_CHECK_EN rejects immediates that do not fit their field.
module inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  inst_encoder_if.slave    bus,
  output logic             err,
  output logic [CNT_W-1:0] inst_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ONE    = 2'd1;
  localparam logic [1:0] FIRST  = 2'd2;
  localparam logic [1:0] SECOND = 2'd3;

  logic [1:0]  state;
  logic [31:0] outInst;
  logic [31:0] pendWord;

  logic [5:0]  opc, funct;
  logic [4:0]  rsF, rtF, rdF, shF;
  logic        known, rType, jType, liOp, twoWords, legal;
  logic [31:0] word0, word1;
  logic        accept;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    opc   = 6'h00;
    funct = 6'h00;
    rsF   = bus.in_rs;
    rtF   = bus.in_rt;
    rdF   = bus.in_rd;
    shF   = bus.in_shamt;
    known = 1'b1;
    rType = 1'b0;
    jType = 1'b0;
    liOp  = 1'b0;
    case (bus.in_op)
      6'd0:  begin rType = 1'b1; funct = 6'h20; end
      6'd1:  begin rType = 1'b1; funct = 6'h21; end
      6'd2:  begin rType = 1'b1; funct = 6'h22; end
      6'd3:  begin rType = 1'b1; funct = 6'h23; end
      6'd4:  begin rType = 1'b1; funct = 6'h24; end
      6'd5:  begin rType = 1'b1; funct = 6'h25; end
      6'd6:  begin rType = 1'b1; funct = 6'h26; end
      6'd7:  begin rType = 1'b1; funct = 6'h27; end
      6'd8:  begin rType = 1'b1; funct = 6'h2a; end
      6'd9:  begin rType = 1'b1; funct = 6'h2b; end
      6'd10: begin rType = 1'b1; funct = 6'h00; rsF = '0; end
      6'd11: begin rType = 1'b1; funct = 6'h02; rsF = '0; end
      6'd12: begin rType = 1'b1; funct = 6'h03; rsF = '0; end
      6'd13: begin rType = 1'b1; funct = 6'h08; rtF = '0; rdF = '0; shF = '0; end
      6'd14: begin rType = 1'b1; funct = 6'h09; end
      6'd15: opc = 6'h23;
      6'd16: opc = 6'h2b;
      6'd17: begin opc = 6'h0f; rsF = '0; end
      6'd18: opc = 6'h08;
      6'd19: opc = 6'h09;
      6'd20: opc = 6'h0c;
      6'd21: opc = 6'h0d;
      6'd22: opc = 6'h0a;
      6'd23: opc = 6'h0b;
      6'd24: opc = 6'h04;
      6'd25: opc = 6'h05;
      6'd26: begin opc = 6'h06; rtF = '0; end
      6'd27: begin opc = 6'h07; rtF = '0; end
      6'd28: begin opc = 6'h01; rtF = 5'd0; end
      6'd29: begin opc = 6'h01; rtF = 5'd1; end
      6'd30: begin jType = 1'b1; opc = 6'h02; end
      6'd31: begin jType = 1'b1; opc = 6'h03; end
      6'd32: begin rType = 1'b1; opc = 6'h1c; funct = 6'h02; end
      6'd33: liOp = 1'b1;
      6'd34: begin rType = 1'b1; rsF = '0; rtF = '0; rdF = '0; shF = '0; end
      default: known = 1'b0;
    endcase
  end

  // LI picks the shortest LUI/ORI sequence that materialises the constant.
  always_comb begin
    word0    = '0;
    word1    = '0;
    twoWords = 1'b0;
    if (rType)
      word0 = {opc, rsF, rtF, rdF, shF, funct};
    else if (jType)
      word0 = {opc, bus.in_imm[25:0]};
    else if (liOp) begin
      if (bus.in_imm[31:16] == 16'h0)
        word0 = {6'h0d, 5'd0, bus.in_rt, bus.in_imm[15:0]};
      else begin
        word0    = {6'h0f, 5'd0, bus.in_rt, bus.in_imm[31:16]};
        word1    = {6'h0d, bus.in_rt, bus.in_rt, bus.in_imm[15:0]};
        twoWords = (bus.in_imm[15:0] != 16'h0);
      end
    end else
      word0 = {opc, rsF, rtF, bus.in_imm[15:0]};
  end

`ifdef IMM_RANGE_CHECK_EN
  logic rangeOk;

  always_comb begin
    rangeOk = 1'b1;
    case (bus.in_op)
      6'd15, 6'd16, 6'd18, 6'd19, 6'd22, 6'd23,
      6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29:
        rangeOk = (bus.in_imm[31:16] == {16{bus.in_imm[15]}});
      6'd17, 6'd20, 6'd21:
        rangeOk = (bus.in_imm[31:16] == 16'h0);
      6'd30, 6'd31:
        rangeOk = (bus.in_imm[31:26] == 6'h0);
      default: rangeOk = 1'b1;
    endcase
  end

  assign legal = known && rangeOk;
`else
  assign legal = known;
`endif

  assign bus.in_ready  = (state == IDLE) ||
                         (((state == ONE) || (state == SECOND)) && bus.out_ready);
  assign bus.out_valid = (state != IDLE);
  assign bus.out_last  = (state == ONE) || (state == SECOND);
  assign bus.out_inst  = outInst;
  assign accept        = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      outInst    <= '0;
      pendWord   <= '0;
      err        <= 1'b0;
      inst_count <= '0;
    end else begin
      err <= accept && !legal;
      if (bus.out_valid && bus.out_ready)
        inst_count <= inst_count + CNT_W'(1);
      if (accept) begin
        if (!legal)
          state <= IDLE;
        else begin
          state    <= twoWords ? FIRST : ONE;
          outInst  <= word0;
          pendWord <= word1;
        end
      end else if ((state == FIRST) && bus.out_ready) begin
        state   <= SECOND;
        outInst <= pendWord;
      end else if (((state == ONE) || (state == SECOND)) && bus.out_ready)
        state <= IDLE;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder; expected words are hand-encoded.
module tb_inst_encoder;

  logic        clk;
  logic        reset_n;
  logic        err;
  logic [15:0] instCount;
  int          errors;
  int          checks;
  logic [15:0] expCount;

  inst_encoder_if bus ();

  inst_encoder #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .err        (err),
    .inst_count (instCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
    bus.in_op    = op;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_shamt = sh;
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
  endtask

  // Presents one request at a negedge and returns at the negedge after acceptance.
  task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
    int n;
    drive(op, rs, rt, rd, sh, imm);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic single(input string tag, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [31:0] imm, input logic [31:0] exp);
    issue(op, rs, rt, rd, sh, imm);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".inst"}, bus.out_inst, exp);
    check({tag, ".last"}, 32'(bus.out_last), 32'd1);
    @(negedge clk);
    expCount++;
    check({tag, ".count"}, 32'(instCount), 32'(expCount));
    check({tag, ".idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    expCount     = '0;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_rs    = '0;
    bus.in_rt    = '0;
    bus.in_rd    = '0;
    bus.in_shamt = '0;
    bus.in_imm   = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_inst", bus.out_inst, 32'd0);
    check("rst.out_last", 32'(bus.out_last), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.count", 32'(instCount), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    single("add",   6'd0,  5'd1, 5'd2,  5'd3, 5'd0, 32'h0,        32'h00221820);
    single("addi",  6'd18, 5'd0, 5'd8,  5'd0, 5'd0, 32'hFFFFFFFF, 32'h2008FFFF);
    single("bgez",  6'd29, 5'd4, 5'd0,  5'd0, 5'd0, 32'h3,        32'h04810003);
    single("sll",   6'd10, 5'd7, 5'd3,  5'd2, 5'd4, 32'h0,        32'h00031100);
    single("jr",    6'd13, 5'd31, 5'd5, 5'd6, 5'd7, 32'h0,        32'h03E00008);
    single("j",     6'd30, 5'd0, 5'd0,  5'd0, 5'd0, 32'h00001234, 32'h08001234);
    single("lui",   6'd17, 5'd5, 5'd2,  5'd0, 5'd0, 32'h0000ABCD, 32'h3C02ABCD);
    single("mul",   6'd32, 5'd1, 5'd2,  5'd3, 5'd0, 32'h0,        32'h70221802);
    single("nop",   6'd34, 5'd9, 5'd9,  5'd9, 5'd9, 32'hFFFFFFFF, 32'h00000000);
    single("bltz",  6'd28, 5'd4, 5'd9,  5'd0, 5'd0, 32'hFFFFFFFE, 32'h0480FFFE);
    single("blez",  6'd26, 5'd3, 5'd7,  5'd0, 5'd0, 32'h8,        32'h18600008);
    single("li_lo", 6'd33, 5'd0, 5'd4,  5'd0, 5'd0, 32'h00005678, 32'h34045678);
    single("li_hi", 6'd33, 5'd0, 5'd4,  5'd0, 5'd0, 32'h00120000, 32'h3C040012);

    // Back-to-back: the second request is taken while the first word drains.
    drive(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    @(negedge clk);
    check("b2b.first", bus.out_inst, 32'h00221820);
    check("b2b.in_ready", 32'(bus.in_ready), 32'd1);
    drive(6'd5, 5'd6, 5'd7, 5'd5, 5'd0, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    expCount++;
    check("b2b.second", bus.out_inst, 32'h00C72825);
    check("b2b.count1", 32'(instCount), 32'(expCount));
    @(negedge clk);
    expCount++;
    check("b2b.count2", 32'(instCount), 32'(expCount));

    // LI two-word expansion at full rate.
    issue(6'd33, 5'd0, 5'd9, 5'd0, 5'd0, 32'h12345678);
    check("li2.w0", bus.out_inst, 32'h3C091234);
    check("li2.last0", 32'(bus.out_last), 32'd0);
    check("li2.rdy_first", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    expCount++;
    check("li2.w1", bus.out_inst, 32'h35295678);
    check("li2.last1", 32'(bus.out_last), 32'd1);
    check("li2.count1", 32'(instCount), 32'(expCount));
    @(negedge clk);
    expCount++;
    check("li2.count2", 32'(instCount), 32'(expCount));
    check("li2.idle", 32'(bus.out_valid), 32'd0);

    // LI under backpressure, then reset while the second word is held.
    bus.out_ready = 1'b0;
    issue(6'd33, 5'd0, 5'd9, 5'd0, 5'd0, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      check("bp.hold_inst", bus.out_inst, 32'h3C091234);
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      check("bp.count", 32'(instCount), 32'(expCount));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    expCount++;
    check("bp.w1", bus.out_inst, 32'h35295678);
    check("bp.count1", 32'(instCount), 32'(expCount));
    bus.out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("bp.rst_valid", 32'(bus.out_valid), 32'd0);
    check("bp.rst_count", 32'(instCount), 32'd0);
    expCount = '0;
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp.post_valid", 32'(bus.out_valid), 32'd0);
    check("bp.post_count", 32'(instCount), 32'd0);

    // Illegal op: handshake completes, one-cycle err, no word.
    issue(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    check("ill.err", 32'(err), 32'd1);
    check("ill.valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("ill.err_clr", 32'(err), 32'd0);
    check("ill.count", 32'(instCount), 32'(expCount));

    // ADDI whose immediate does not fit 16 signed bits.
    issue(6'd18, 5'd0, 5'd0, 5'd0, 5'd0, 32'h00010000);
`ifdef IMM_RANGE_CHECK_EN
    check("rng.err", 32'(err), 32'd1);
    check("rng.valid", 32'(bus.out_valid), 32'd0);
`else
    check("rng.err", 32'(err), 32'd0);
    check("rng.inst", bus.out_inst, 32'h20000000);
    expCount++;
`endif
    @(negedge clk);
    check("rng.count", 32'(instCount), 32'(expCount));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
